// File: rtl/video_pkg.sv
// Shared video geometry and pixel/address types for the background RAM,
// the fetch stage and the sprite compositor.
package video_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned RGB_W    = 24;
  localparam int unsigned SPEED_W  = 4;

  typedef logic [23:0] rgb_t;
  typedef logic [18:0] fb_addr_t;

endpackage

// File: rtl/sideband_delay.sv
// Reset-to-zero shift register of configurable width and depth, used to keep
// sideband bits aligned with a fixed-latency datapath.
module sideband_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/background_fetch.sv
// Background pixel fetch: coordinates plus per-frame vertical scroll offset
// into a RAM address, returned pixel re-timed with its display enable.
module background_fetch
  import video_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               de_in,
  input  logic               frame_start,
  input  logic               scroll_en,
  input  logic [SPEED_W-1:0] scroll_speed,
  input  logic [3:0]         scroll_div,
  output logic [ADDR_W-1:0]  read_address,
  input  logic [RGB_W-1:0]   ram_data,
  output logic [RGB_W-1:0]   bg_rgb,
  output logic               de_out,
  output logic [9:0]         scroll_offset
);

  logic [9:0]  offset_q, offset_d;
  logic [3:0]  fc_q, fc_d;
  logic [9:0]  speed;
  logic [10:0] sum_y, src_y11;
  logic [9:0]  src_y;
  fb_addr_t    addr;
  logic        in_range;
  logic        valid_s2, de_s2;

  assign speed = 10'(scroll_speed);

  always_comb begin
    offset_d = offset_q;
    fc_d     = fc_q;
    if (frame_start && scroll_en) begin
      if (fc_q == scroll_div) begin
        fc_d = '0;
        // Borrow-wrap keeps the offset in 0..V_ACTIVE-1 without a modulo.
        if (offset_q < speed) offset_d = offset_q + 10'(V_ACTIVE) - speed;
        else                  offset_d = offset_q - speed;
      end else begin
        fc_d = fc_q + 4'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      offset_q <= '0;
      fc_q     <= '0;
    end else begin
      offset_q <= offset_d;
      fc_q     <= fc_d;
    end
  end

  assign sum_y   = {1'b0, DrawY} + {1'b0, offset_q};
  assign src_y11 = (sum_y >= 11'(V_ACTIVE)) ? sum_y - 11'(V_ACTIVE) : sum_y;
  assign src_y   = src_y11[9:0];

  // src_y*640 as (src_y<<9) + (src_y<<7).
  assign addr = {src_y, 9'b0} + {2'b0, src_y, 7'b0} + {9'b0, DrawX};

  assign in_range = de_in && (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));

  sideband_delay #(
    .WIDTH(2),
    .DEPTH(2)
  ) u_sideband (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .d_i    ({in_range, de_in}),
    .q_o    ({valid_s2, de_s2})
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      read_address <= '0;
      bg_rgb       <= '0;
      de_out       <= 1'b0;
    end else begin
      read_address <= in_range ? addr : '0;
      bg_rgb       <= valid_s2 ? ram_data : '0;
      de_out       <= de_s2;
    end
  end

  assign scroll_offset = offset_q;

endmodule

// File: doc/background_fetch.md
# background_fetch

Pixel-fetch stage directly upstream of the background RAM (640×480, 24-bit RGB, one-cycle registered read). It converts the VGA controller's current pixel coordinates into a RAM read address and applies a per-frame vertical scroll offset, so the starfield drifts downward. It re-times the returned pixel, together with its display-enable sideband, into a registered RGB stream for the sprite compositor. All address arithmetic is shift/add; there is no multiplier.

## Interface
- H_ACTIVE, 640, visible pixels per line; also the RAM row pitch
- V_ACTIVE, 480, visible lines; also the RAM row count
- ADDR_W, 19, RAM address width
- RGB_W, 24, pixel width
- SPEED_W, 4, scroll-speed field width
- Clk  in  1  single clock, shared with the RAM and the VGA controller
- Reset_n  in  1  synchronous, active-low reset
- DrawX  in  10  current pixel column from the VGA controller
- DrawY  in  10  current pixel line from the VGA controller
- de_in  in  1  display enable, aligned with DrawX/DrawY
- frame_start  in  1  one-cycle pulse in vertical blank, once per frame
- scroll_en  in  1  enables scrolling; sampled only at frame_start
- scroll_speed  in  SPEED_W  lines per scroll step; sampled only at frame_start
- scroll_div  in  4  frames per scroll step, minus 1; sampled only at frame_start
- read_address  out  ADDR_W  to RAM read_address; registered
- ram_data  in  RGB_W  from RAM data_Out
- bg_rgb  out  RGB_W  background pixel to compositor; registered
- de_out  out  1  display enable aligned with bg_rgb
- scroll_offset  out  10  current offset, 0..V_ACTIVE-1, for debug

## Operation
- **Offset state:** offset register (0..479) plus a frame counter fc (4-bit).
- **On frame_start with scroll_en=1:**
  - If fc == scroll_div: fc←0 and offset←(offset − scroll_speed) mod 480, using borrow-wrap (if offset < speed, add 480).
  - Otherwise fc←fc+1.
- **On frame_start with scroll_en=0:** offset and fc hold.
- **Offset update timing:** the offset changes only on frame_start, so a frame is never torn. Changing scroll_en, scroll_speed or scroll_div mid-frame has no effect until the next frame_start.
- **Source line:** src_y = DrawY + offset, minus 480 if the sum ≥ 480. Compute it in an 11-bit sum; src_y is always in 0..479.
- **Address:** (src_y<<9) + (src_y<<7) + DrawX, i.e. src_y·640 + DrawX.
- **Out-of-range pixels:** if DrawX ≥ 640, DrawY ≥ 480, or de_in=0:
  - the pixel is out-of-range;
  - read_address←0;
  - a valid bit in the pipeline is cleared;
  - bg_rgb is forced to 0 when that pixel reaches the output.
- **Output stage:** bg_rgb←valid ? ram_data : 0; de_out←the delayed de_in.
- **Write port:** this block never writes the RAM; the RAM's we is tied low at the top level.
- **Reset:** Reset_n=0 at a clock edge sets read_address=0, bg_rgb=0, de_out=0, scroll_offset=0, fc=0, and clears all pipeline valid/de bits. Reset has priority over frame_start in the same cycle.

## Timing
- **Pixel pipeline stages:**
  - Cycle n: DrawX/DrawY/de_in presented.
  - Edge n+1: read_address registered.
  - Edge n+2: RAM data_Out valid.
  - Edge n+3: bg_rgb and de_out registered.
- **Latency:** 3 cycles from coordinate to bg_rgb and de_out. The VGA controller delays hs/vs by 3 to match.
- **Throughput:** one pixel per clock, no stalls, no back-pressure.
- **Offset latency:** the new offset is visible on scroll_offset 1 cycle after frame_start. It is used by the next coordinate presented after that edge.
- **Reset mid-frame:** outputs read 0 on the cycle after the reset edge. The pipeline refills with valid data 3 cycles after Reset_n returns high.

## Structure
- **Shared package video_pkg:** H_ACTIVE, V_ACTIVE, `typedef logic [23:0] rgb_t`, `typedef logic [18:0] fb_addr_t`. The RAM wrapper and the compositor use the same package.
- **Sub-module sideband_delay:** parameterised width and depth shift register, reset to 0. It carries the valid and de bits across the 2 stages after the address register. It is reused for the hs/vs delay in the VGA top.
- **Offset/frame-counter logic:** a single always_ff in this block. It needs no separate module.

## Test plan
- **Basic fetch:** reset, scroll_en=0, DrawX=5, DrawY=2, de_in=1 → read_address=1285 one cycle later. The RAM is preloaded with mem[1285]=0xABCDEF; bg_rgb=0xABCDEF and de_out=1 three cycles after the coordinate.
- **Scroll wrap:** scroll_speed=5, scroll_div=0, scroll_en=1, two frame_start pulses → offset 0→475→470. Then DrawY=20, DrawX=3 → read_address=6403 (src_y=10).
- **Frame divider:** scroll_div=2, speed=1, six frame_starts → offset 0→0→0→479→479→479→478.
- **Out-of-range:** DrawX=700 or DrawY=500 or de_in=0 → read_address=0, bg_rgb=0, de_out matches the delayed de_in, even with mem[0]=0xFFFFFF.
- **Mid-frame change:** speed changed from 5 to 9 mid-frame → no offset change until the next frame_start, then offset drops by 9. scroll_en dropped mid-frame → the offset holds from the next frame_start on.
- **Reset mid-operation:** Reset_n low for 1 cycle during an active line, in the same cycle as frame_start → all outputs and scroll_offset are 0 on the next cycle. A valid pixel appears on bg_rgb exactly 3 cycles after Reset_n rises.
